// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode encodings
// and sizing helpers.
`ifndef FIFO_CNT_W
`define FIFO_CNT_W(depth) ($clog2(depth) + 1)
`endif

package fifo_pkg;
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram_dp.sv
// FIFO storage: synchronous write, asynchronous read. The array has no reset,
// so a flush leaves old samples in place.
module fifo_ram_dp import fifo_pkg::*; #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read, threshold flags, occupancy count, flush and sticky error flags.
module fifo_sync_param import fifo_pkg::*; #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 4,
  parameter  int AE_LEVEL = 2,
  parameter  int MODE     = FIFO_MODE_STD,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             req_put,
  input  logic [WIDTH-1:0] data_put,
  input  logic             req_get,
  output logic [WIDTH-1:0] data_get,
  output logic             full_out,
  output logic             empty_out,
  output logic             almost_full_out,
  output logic             almost_empty_out,
  output logic [CW-1:0]    count_out,
  output logic             overflow_out,
  output logic             underflow_out
);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH) || DEPTH < 4 || (1 << AW) != DEPTH)
  begin : g_bad_param
    $fatal(1, "fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             do_put, do_get;

  // Occupancy alone decides full/empty; pointers are free-running mod DEPTH.
  assign full_out         = (count == FULL_C);
  assign empty_out        = (count == '0);
  assign almost_full_out  = (count >= AF_C);
  assign almost_empty_out = (count <= AE_C);
  assign count_out        = count;

  assign do_put = req_put && !full_out  && !clear;
  assign do_get = req_get && !empty_out && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (do_put) wr_ptr <= wr_ptr + AW'(1);
      if (do_get) rd_ptr <= rd_ptr + AW'(1);
      case ({do_put, do_get})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (req_put && full_out)  overflow_out  <= 1'b1;
      if (req_get && empty_out) underflow_out <= 1'b1;
    end
  end

  fifo_ram_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (do_put),
    .waddr(wr_ptr),
    .wdata(data_put),
    .raddr(rd_ptr),
    .rdata(head)
  );

  if (MODE == FIFO_MODE_FWFT) begin : g_fwft
    assign data_get = empty_out ? '0 : head;
  end else begin : g_std
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       data_q <= '0;
      else if (clear)  data_q <= '0;
      else if (do_get) data_q <= head;
    end
    assign data_get = data_q;
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: a standard-read and an FWFT instance share one stimulus
// stream; expected data is queued on accepted puts and popped on accepted gets.
module tb_fifo_sync_param;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = 5;
  localparam int NSAMP = 44100;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear = 1'b0, req_put = 1'b0, req_get = 1'b0;
  logic [W-1:0] data_put = '0;

  logic [W-1:0]  s_data, f_data;
  logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [CW-1:0] s_count, f_count;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(2), .MODE(0)) u_std (
    .clk(clk), .reset(reset), .clear(clear), .req_put(req_put), .data_put(data_put),
    .req_get(req_get), .data_get(s_data), .full_out(s_full), .empty_out(s_empty),
    .almost_full_out(s_af), .almost_empty_out(s_ae), .count_out(s_count),
    .overflow_out(s_ov), .underflow_out(s_un));

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(2), .MODE(1)) u_fwft (
    .clk(clk), .reset(reset), .clear(clear), .req_put(req_put), .data_put(data_put),
    .req_get(req_get), .data_get(f_data), .full_out(f_full), .empty_out(f_empty),
    .almost_full_out(f_af), .almost_empty_out(f_ae), .count_out(f_count),
    .overflow_out(f_ov), .underflow_out(f_un));

  // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit g,
                       output bit got, output logic [W-1:0] exp);
    bit acc_p, acc_g;
    acc_p = p && (sb.size() < D);
    acc_g = g && (sb.size() > 0);
    req_put = p; data_put = d; req_get = g;
    got = acc_g;
    exp = '0;
    if (acc_g) exp = sb.pop_front();
    if (acc_p) sb.push_back(d);
    @(posedge clk); #1;
    req_put = 1'b0; req_get = 1'b0;
  endtask

  task automatic do_clear();
    sb.delete();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #7;
    n_vec++;
    if ({s_data, s_full, s_empty, s_af, s_ae, s_count, s_ov, s_un} !==
        {32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_std got data=%h f=%b e=%b af=%b ae=%b cnt=%0d ov=%b un=%b",
               s_data, s_full, s_empty, s_af, s_ae, s_count, s_ov, s_un);
    end
    n_vec++;
    if ({f_data, f_empty, f_count} !== {32'h0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL reset_fwft got data=%h e=%b cnt=%0d exp 0/1/0", f_data, f_empty, f_count);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_fill();
    bit got; logic [W-1:0] exp;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, W'(i), 1'b0, got, exp);
      if (i == 1) begin
        n_vec++;
        if (s_empty !== 1'b0 || s_count !== 5'd1) begin
          n_err++; $display("FAIL first_put got e=%b cnt=%0d exp e=0 cnt=1", s_empty, s_count);
        end
      end
      if (i == 2 || i == 3) begin
        n_vec++;
        if (s_ae !== (i == 2)) begin
          n_err++; $display("FAIL ae_boundary cnt=%0d got ae=%b exp %b", i, s_ae, i == 2);
        end
      end
      if (i == 11 || i == 12) begin
        n_vec++;
        if (s_af !== (i == 12)) begin
          n_err++; $display("FAIL af_boundary cnt=%0d got af=%b exp %b", i, s_af, i == 12);
        end
      end
    end
    n_vec++;
    if (s_full !== 1'b1 || s_count !== 5'd16 || s_ov !== 1'b0) begin
      n_err++; $display("FAIL full got f=%b cnt=%0d ov=%b exp 1/16/0", s_full, s_count, s_ov);
    end
    cycle(1'b1, 32'h11, 1'b0, got, exp);
    n_vec++;
    if (s_ov !== 1'b1 || s_count !== 5'd16 || s_un !== 1'b0) begin
      n_err++; $display("FAIL overflow got ov=%b cnt=%0d un=%b exp 1/16/0", s_ov, s_count, s_un);
    end
  endtask

  task automatic test_drain_std();
    bit got; logic [W-1:0] exp;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, '0, 1'b1, got, exp);
      n_vec++;
      if (s_data !== W'(i) || exp !== W'(i)) begin
        n_err++; $display("FAIL drain_data idx=%0d got %h exp %h", i, s_data, i);
      end
    end
    n_vec++;
    if (s_empty !== 1'b1 || s_count !== 5'd0) begin
      n_err++; $display("FAIL drain_empty got e=%b cnt=%0d exp 1/0", s_empty, s_count);
    end
    cycle(1'b0, '0, 1'b1, got, exp);
    n_vec++;
    if (s_un !== 1'b1 || s_data !== 32'h10 || s_count !== 5'd0) begin
      n_err++; $display("FAIL underflow got un=%b data=%h cnt=%0d exp 1/10/0", s_un, s_data, s_count);
    end
  endtask

  task automatic test_back_to_back();
    bit got; logic [W-1:0] exp;
    do_clear();
    n_vec++;
    if (s_ov !== 1'b0 || s_un !== 1'b0 || s_count !== 5'd0) begin
      n_err++; $display("FAIL clear_flags got ov=%b un=%b cnt=%0d exp 0/0/0", s_ov, s_un, s_count);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + W'(i), 1'b0, got, exp);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 32'h200 + W'(i), 1'b1, got, exp);
      n_vec++;
      // Read stream lags the write stream by exactly 8 entries.
      if (s_count !== 5'd8 || !got || s_data !== exp ||
          exp !== ((i < 8) ? 32'h100 + W'(i) : 32'h200 + W'(i - 8))) begin
        n_err++; $display("FAIL b2b cyc=%0d got data=%h cnt=%0d exp data=%h cnt=8", i, s_data, s_count, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1, got, exp);
      n_vec++;
      if (s_data !== exp) begin
        n_err++; $display("FAIL b2b_drain idx=%0d got %h exp %h", i, s_data, exp);
      end
    end
  endtask

  task automatic test_fwft();
    bit got; logic [W-1:0] exp;
    cycle(1'b1, 32'hDEADBEEF, 1'b0, got, exp);
    n_vec++;
    if (f_data !== 32'hDEADBEEF || f_empty !== 1'b0) begin
      n_err++; $display("FAIL fwft_head got data=%h e=%b exp deadbeef/0", f_data, f_empty);
    end
    cycle(1'b0, '0, 1'b1, got, exp);
    n_vec++;
    if (f_data !== 32'h0 || f_empty !== 1'b1) begin
      n_err++; $display("FAIL fwft_pop got data=%h e=%b exp 0/1", f_data, f_empty);
    end
    n_vec++;
    if (s_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL std_after_fwft got %h exp deadbeef", s_data);
    end
  endtask

  task automatic test_clear();
    bit got; logic [W-1:0] exp;
    for (int i = 0; i < 17; i++) cycle(1'b1, 32'hA00 + W'(i), 1'b0, got, exp);
    for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1, got, exp);
    n_vec++;
    if (s_count !== 5'd5 || s_ov !== 1'b1) begin
      n_err++; $display("FAIL pre_clear got cnt=%0d ov=%b exp 5/1", s_count, s_ov);
    end
    do_clear();
    n_vec++;
    if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ov !== 1'b0 || s_data !== 32'h0) begin
      n_err++; $display("FAIL clear got cnt=%0d e=%b ov=%b data=%h exp 0/1/0/0", s_count, s_empty, s_ov, s_data);
    end
    cycle(1'b1, 32'hA5A5A5A5, 1'b0, got, exp);
    cycle(1'b0, '0, 1'b1, got, exp);
    n_vec++;
    if (s_data !== 32'hA5A5A5A5 || exp !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL clear_reuse got %h exp a5a5a5a5", s_data);
    end
  endtask

  task automatic test_async_reset_stream();
    bit got, p, g, acc_p;
    logic [W-1:0] exp;
    int np, nr, cyc;
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'hB00 + W'(i), 1'b0, got, exp);
    req_put = 1'b1; data_put = 32'hBEEF;
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({s_data, s_full, s_empty, s_af, s_ae, s_count, s_ov, s_un, f_data} !==
        {32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset got data=%h e=%b cnt=%0d ov=%b un=%b fdata=%h",
               s_data, s_empty, s_count, s_ov, s_un, f_data);
    end
    req_put = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    np = 0; nr = 0; cyc = 0;
    while (nr < NSAMP && cyc < 90000) begin
      p = (np < NSAMP) && (cyc == 0 || $urandom_range(7) != 0);
      g = ($urandom_range(7) != 0);
      acc_p = p && (sb.size() < D);
      if (sb.size() > 0) begin
        n_vec++;
        if (f_data !== sb[0]) begin
          n_err++;
          if (n_err < 20) $display("FAIL fwft_stream cyc=%0d got %h exp %h", cyc, f_data, sb[0]);
        end
      end
      cycle(p, (32'h5EED0000 ^ (W'(np) * 32'h9E3779B9)), g, got, exp);
      if (acc_p) np++;
      n_vec++;
      if (s_count !== CW'(sb.size())) begin
        n_err++;
        if (n_err < 20) $display("FAIL stream_count cyc=%0d got %0d exp %0d", cyc, s_count, sb.size());
      end
      if (got) begin
        nr++;
        n_vec++;
        if (s_data !== exp) begin
          n_err++;
          if (n_err < 20) $display("FAIL stream_data n=%0d got %h exp %h", nr, s_data, exp);
        end
      end
      cyc++;
    end
    n_vec++;
    if (nr != NSAMP) begin
      n_err++; $display("FAIL stream_timeout got %0d samples exp %0d", nr, NSAMP);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_std();
    test_back_to_back();
    test_fwft();
    test_clear();
    test_async_reset_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
